// File: rtl/riscv_core_mul_div_issue.sv
// riscv_core_mul_div_issue
// Issue/completion controller between the EX stage and the M-extension
// multiply/divide unit. Accepts one op, freezes IF/ID/EX while it is in flight,
// waits for the combinational multiplier (one cycle) or the iterative divider's
// done pulse (guarded by a watchdog), then strobes result + rd to writeback.
//
// Ports:
//   i_mdi_clk, i_mdi_rstn                      clock, async active-low reset
//   i_mdi_valid, i_mdi_flush                   op present in EX / kill
//   i_mdi_srcA/srcB/control/isword/rd          op payload from EX
//   o_mdi_en, o_mdi_srcA/srcB/control/isword   request + latched payload to unit
//   i_mdi_unit_done, i_mdi_unit_result         unit response
//   o_mdi_stall                                combinational pipeline freeze
//   o_mdi_result_valid/result/rd/error         one-cycle writeback strobe + payload
module riscv_core_mul_div_issue #(
    parameter int unsigned XLEN        = 64,
    parameter int unsigned DIV_TIMEOUT = 128
) (
    input  logic            i_mdi_clk,
    input  logic            i_mdi_rstn,
    input  logic            i_mdi_valid,
    input  logic            i_mdi_flush,
    input  logic [XLEN-1:0] i_mdi_srcA,
    input  logic [XLEN-1:0] i_mdi_srcB,
    input  logic [3:0]      i_mdi_control,
    input  logic            i_mdi_isword,
    input  logic [4:0]      i_mdi_rd,
    output logic            o_mdi_en,
    output logic [XLEN-1:0] o_mdi_srcA,
    output logic [XLEN-1:0] o_mdi_srcB,
    output logic [3:0]      o_mdi_control,
    output logic            o_mdi_isword,
    input  logic            i_mdi_unit_done,
    input  logic [XLEN-1:0] i_mdi_unit_result,
    output logic            o_mdi_stall,
    output logic            o_mdi_result_valid,
    output logic [XLEN-1:0] o_mdi_result,
    output logic [4:0]      o_mdi_rd,
    output logic            o_mdi_error
);

    // Counter only needs to reach DIV_TIMEOUT-1.
    localparam int unsigned CNT_W = (DIV_TIMEOUT > 1) ? $clog2(DIV_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_RESP = 2'd3
    } state_e;

    state_e            state_q,  state_d;
    logic              en_q,     en_d;
    logic [XLEN-1:0]   srca_q,   srca_d;
    logic [XLEN-1:0]   srcb_q,   srcb_d;
    logic [3:0]        ctl_q,    ctl_d;
    logic              isw_q,    isw_d;
    logic [4:0]        rd_lat_q, rd_lat_d;
    logic [4:0]        rd_q,     rd_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic              error_q,  error_d;
    logic              rv_q,     rv_d;
    logic [CNT_W-1:0]  cnt_q,    cnt_d;

    // Next-state and register-update logic.
    always_comb begin
        state_d  = state_q;
        en_d     = en_q;
        srca_d   = srca_q;
        srcb_d   = srcb_q;
        ctl_d    = ctl_q;
        isw_d    = isw_q;
        rd_lat_d = rd_lat_q;
        rd_d     = rd_q;
        result_d = result_q;
        error_d  = error_q;
        rv_d     = 1'b0;
        cnt_d    = cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (i_mdi_valid && !i_mdi_flush) begin
                    srca_d   = i_mdi_srcA;
                    srcb_d   = i_mdi_srcB;
                    ctl_d    = i_mdi_control;
                    isw_d    = i_mdi_isword;
                    rd_lat_d = i_mdi_rd;
                    cnt_d    = '0;
                    en_d     = 1'b1;
                    state_d  = i_mdi_control[2] ? ST_DIV : ST_MUL;
                end
            end
            ST_MUL: begin
                en_d = 1'b0;
                if (i_mdi_flush) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    result_d = i_mdi_unit_result;
                    error_d  = 1'b0;
                    rd_d     = rd_lat_q;
                    rv_d     = 1'b1;
                    state_d  = ST_RESP;
                end
            end
            ST_DIV: begin
                if (i_mdi_flush) begin
                    en_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else if (i_mdi_unit_done) begin
                    // Done takes priority over a coincident watchdog expiry.
                    en_d     = 1'b0;
                    result_d = i_mdi_unit_result;
                    error_d  = 1'b0;
                    rd_d     = rd_lat_q;
                    rv_d     = 1'b1;
                    state_d  = ST_RESP;
                end else if (cnt_q == CNT_LAST) begin
                    en_d     = 1'b0;
                    result_d = '0;
                    error_d  = 1'b1;
                    rd_d     = rd_lat_q;
                    rv_d     = 1'b1;
                    state_d  = ST_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RESP: begin
                // EX still shows the retiring op here, so valid is not looked at.
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge i_mdi_clk or negedge i_mdi_rstn) begin
        if (!i_mdi_rstn) begin
            state_q  <= ST_IDLE;
            en_q     <= 1'b0;
            srca_q   <= '0;
            srcb_q   <= '0;
            ctl_q    <= '0;
            isw_q    <= 1'b0;
            rd_lat_q <= '0;
            rd_q     <= '0;
            result_q <= '0;
            error_q  <= 1'b0;
            rv_q     <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            en_q     <= en_d;
            srca_q   <= srca_d;
            srcb_q   <= srcb_d;
            ctl_q    <= ctl_d;
            isw_q    <= isw_d;
            rd_lat_q <= rd_lat_d;
            rd_q     <= rd_d;
            result_q <= result_d;
            error_q  <= error_d;
            rv_q     <= rv_d;
            cnt_q    <= cnt_d;
        end
    end

    // Stall covers the issue cycle itself so EX holds the op being latched.
    assign o_mdi_stall = ((state_q == ST_IDLE) && i_mdi_valid && !i_mdi_flush)
                       || (state_q == ST_MUL) || (state_q == ST_DIV);

    assign o_mdi_en           = en_q;
    assign o_mdi_srcA         = srca_q;
    assign o_mdi_srcB         = srcb_q;
    assign o_mdi_control      = ctl_q;
    assign o_mdi_isword       = isw_q;
    assign o_mdi_result_valid = rv_q;
    assign o_mdi_result       = result_q;
    assign o_mdi_rd           = rd_q;
    assign o_mdi_error        = error_q;

endmodule

// File: tb/tb_riscv_core_mul_div_issue.sv
// Bench for riscv_core_mul_div_issue: directed scenarios with literal
// expectations, then randomized traffic against an op-level reference model.
module tb_riscv_core_mul_div_issue;

    localparam int unsigned XLEN = 64;
    localparam int unsigned TMO  = 16;

    logic            clk, rstn;
    logic            valid, flush;
    logic [XLEN-1:0] srca, srcb;
    logic [3:0]      ctl;
    logic            isw;
    logic [4:0]      rd;
    logic            en;
    logic [XLEN-1:0] o_srca, o_srcb;
    logic [3:0]      o_ctl;
    logic            o_isw;
    logic            done;
    logic [XLEN-1:0] unit_res;
    logic            stall, rv;
    logic [XLEN-1:0] res;
    logic [4:0]      o_rd;
    logic            err;
    logic [XLEN-1:0] junk;

    int errors = 0;
    int checks = 0;

    riscv_core_mul_div_issue #(.XLEN(XLEN), .DIV_TIMEOUT(TMO)) dut (
        .i_mdi_clk          (clk),
        .i_mdi_rstn         (rstn),
        .i_mdi_valid        (valid),
        .i_mdi_flush        (flush),
        .i_mdi_srcA         (srca),
        .i_mdi_srcB         (srcb),
        .i_mdi_control      (ctl),
        .i_mdi_isword       (isw),
        .i_mdi_rd           (rd),
        .o_mdi_en           (en),
        .o_mdi_srcA         (o_srca),
        .o_mdi_srcB         (o_srcb),
        .o_mdi_control      (o_ctl),
        .o_mdi_isword       (o_isw),
        .i_mdi_unit_done    (done),
        .i_mdi_unit_result  (unit_res),
        .o_mdi_stall        (stall),
        .o_mdi_result_valid (rv),
        .o_mdi_result       (res),
        .o_mdi_rd           (o_rd),
        .o_mdi_error        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in execution unit: combinational multiplier, divider answers on done.
    function automatic logic [XLEN-1:0] f_mul(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        return a * b;
    endfunction

    function automatic logic [XLEN-1:0] f_div(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                                             input logic [3:0] c);
        if (b == '0) return '1;
        return c[1] ? (a % b) : (a / b);
    endfunction

    assign unit_res = !en ? junk
                    : (!o_ctl[2] ? f_mul(o_srca, o_srcb)
                    : (done ? f_div(o_srca, o_srcb, o_ctl) : junk));

    // Reference model: one op record plus expected registered outputs.
    bit              m_busy, m_div;
    int unsigned     m_wait, div_lat;
    logic [XLEN-1:0] m_a, m_b;
    logic [3:0]      m_ctl;
    logic [4:0]      m_rd;
    logic            e_en, e_isw, e_rv, e_err;
    logic [XLEN-1:0] e_a, e_b, e_res;
    logic [3:0]      e_ctl;
    logic [4:0]      e_rd;
    bit              ex_adv = 1'b1;

    task automatic model_reset();
        m_busy = 0; m_div = 0; m_wait = 0;
        m_a = '0; m_b = '0; m_ctl = '0; m_rd = '0;
        e_en = 0; e_isw = 0; e_rv = 0; e_err = 0;
        e_a = '0; e_b = '0; e_res = '0; e_ctl = '0; e_rd = '0;
    endtask

    // Advance the model across one clock edge using the inputs of the ending cycle.
    task automatic model_step();
        bit              was_resp, fin;
        logic [XLEN-1:0] r;
        logic            er;
        was_resp = e_rv;
        e_rv = 0;
        fin = 0; r = '0; er = 0;
        if (m_busy) begin
            if (flush) begin
                m_busy = 0; e_en = 0;
            end else if (!m_div) begin
                fin = 1; r = f_mul(m_a, m_b); er = 0;
            end else if (done) begin
                fin = 1; r = f_div(m_a, m_b, m_ctl); er = 0;
            end else begin
                m_wait++;
                if (m_wait == TMO) begin fin = 1; r = '0; er = 1; end
            end
            if (fin) begin
                m_busy = 0; e_en = 0; e_rv = 1;
                e_res = r; e_err = er; e_rd = m_rd;
            end
        end else if (!was_resp && valid && !flush) begin
            m_busy = 1; m_div = ctl[2]; m_wait = 0;
            m_a = srca; m_b = srcb; m_ctl = ctl; m_rd = rd;
            e_en = 1; e_a = srca; e_b = srcb; e_ctl = ctl; e_isw = isw;
        end
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare every output against the model, mid-cycle.
    task automatic sample();
        logic exp_stall;
        @(negedge clk);
        exp_stall = m_busy || (!e_rv && valid && !flush);
        chk("stall",   64'(stall), 64'(exp_stall));
        chk("en",      64'(en),    64'(e_en));
        chk("srcA",    o_srca,     e_a);
        chk("srcB",    o_srcb,     e_b);
        chk("control", 64'(o_ctl), 64'(e_ctl));
        chk("isword",  64'(o_isw), 64'(e_isw));
        chk("rvalid",  64'(rv),    64'(e_rv));
        chk("result",  res,        e_res);
        chk("rd",      64'(o_rd),  64'(e_rd));
        chk("error",   64'(err),   64'(e_err));
        ex_adv = !exp_stall || flush;
    endtask

    task automatic advance();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic set_done(input bit stale);
        if (m_busy && m_div) done = (m_wait + 1 == div_lat);
        else                 done = stale;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_en"},  64'(en),    64'd0);
        chk({tag, "_sa"},  o_srca,     64'd0);
        chk({tag, "_sb"},  o_srcb,     64'd0);
        chk({tag, "_ctl"}, 64'(o_ctl), 64'd0);
        chk({tag, "_isw"}, 64'(o_isw), 64'd0);
        chk({tag, "_rv"},  64'(rv),    64'd0);
        chk({tag, "_res"}, res,        64'd0);
        chk({tag, "_rd"},  64'(o_rd),  64'd0);
        chk({tag, "_err"}, 64'(err),   64'd0);
        chk({tag, "_stl"}, 64'(stall), 64'd0);
    endtask

    task automatic set_op(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                          input logic [3:0] c, input logic [4:0] d);
        valid = 1; srca = a; srcb = b; ctl = c; isw = 0; rd = d; flush = 0;
    endtask

    task automatic new_instr();
        valid = ($urandom_range(0, 3) != 0);
        srca  = ($urandom_range(0, 3) == 0) ? 64'($urandom_range(0, 20)) : {$urandom, $urandom};
        srcb  = ($urandom_range(0, 3) == 0) ? 64'($urandom_range(0, 3))  : {$urandom, $urandom};
        ctl   = 4'($urandom);
        isw   = 1'($urandom);
        rd    = 5'($urandom);
    endtask

    // Run a divide to completion; report enable cycles and the strobe payload.
    task automatic run_until_rv(output int en_cnt, output bit seen, output logic [XLEN-1:0] r,
                                output logic e, output logic [4:0] d, output logic s);
        en_cnt = 0; seen = 0; r = '0; e = 0; d = '0; s = 1;
        for (int i = 0; i < 60 && !seen; i++) begin
            set_done(0);
            sample();
            if (en) en_cnt++;
            if (rv) begin seen = 1; r = res; e = err; d = o_rd; s = stall; end
            advance();
        end
        valid = 0;
    endtask

    int              en_cnt, rv_cnt, pulses, idx;
    bit              seen;
    logic [XLEN-1:0] g_res;
    logic            g_err, g_stall;
    logic [4:0]      g_rd;
    logic [XLEN-1:0] p_res [2];
    logic [4:0]      p_rd  [2];

    initial begin
        rstn = 0; valid = 0; flush = 0; srca = '0; srcb = '0; ctl = '0; isw = 0; rd = '0;
        done = 0; junk = '0; div_lat = 100;
        model_reset();
        #12;
        check_zero("reset");
        @(negedge clk); rstn = 1;
        advance();

        // MUL 7*6 -> 42 to rd 5 two cycles after issue.
        set_op(64'd7, 64'd6, 4'b0000, 5'd5);
        set_done(0); sample(); chk("mul_c0_stall", 64'(stall), 64'd1); advance();
        sample(); chk("mul_c1_en", 64'(en), 64'd1); chk("mul_c1_stall", 64'(stall), 64'd1); advance();
        sample();
        chk("mul_c2_rv", 64'(rv), 64'd1); chk("mul_c2_res", res, 64'd42);
        chk("mul_c2_rd", 64'(o_rd), 64'd5); chk("mul_c2_err", 64'(err), 64'd0);
        chk("mul_c2_stall", 64'(stall), 64'd0);
        advance();
        valid = 0; sample(); chk("mul_c3_rv", 64'(rv), 64'd0); advance();

        // DIV 100/7 -> 14, done in the 10th divide cycle.
        set_op(64'd100, 64'd7, 4'b0100, 5'd9); div_lat = 10;
        run_until_rv(en_cnt, seen, g_res, g_err, g_rd, g_stall);
        chk("div_seen", 64'(seen), 64'd1); chk("div_en_cycles", 64'(en_cnt), 64'd10);
        chk("div_res", g_res, 64'd14); chk("div_rd", 64'(g_rd), 64'd9);
        chk("div_err", 64'(g_err), 64'd0); chk("div_stall_at_rv", 64'(g_stall), 64'd0);

        // Flush in the 3rd divide cycle, stale done pulse later.
        set_op(64'd55, 64'd5, 4'b0101, 5'd3); div_lat = 100;
        set_done(0); sample(); advance();
        for (int i = 1; i <= 3; i++) begin
            flush = (i == 3); set_done(0); sample(); advance();
        end
        valid = 0; flush = 0; rv_cnt = 0;
        for (int i = 4; i <= 10; i++) begin
            junk = {$urandom, $urandom};
            set_done(i == 8);
            sample();
            if (rv) rv_cnt++;
            chk("flush_en", 64'(en), 64'd0); chk("flush_stall", 64'(stall), 64'd0);
            advance();
        end
        done = 0;
        chk("flush_no_rv", 64'(rv_cnt), 64'd0); chk("flush_res_hold", res, 64'd14);

        // Watchdog: done never arrives.
        set_op(64'd9, 64'd3, 4'b0100, 5'd17); div_lat = TMO + 5;
        run_until_rv(en_cnt, seen, g_res, g_err, g_rd, g_stall);
        chk("tmo_seen", 64'(seen), 64'd1); chk("tmo_en_cycles", 64'(en_cnt), 64'd16);
        chk("tmo_res", g_res, 64'd0); chk("tmo_err", 64'(g_err), 64'd1);
        chk("tmo_rd", 64'(g_rd), 64'd17);
        sample(); chk("tmo_rv_pulse", 64'(rv), 64'd0); advance();

        // Async reset in the middle of a divide, then MUL 3*5.
        set_op(64'd1000, 64'd3, 4'b0100, 5'd4); div_lat = 100;
        for (int i = 0; i < 4; i++) begin set_done(0); sample(); advance(); end
        valid = 0;
        #2 rstn = 0;
        #1 check_zero("midrst");
        model_reset();
        @(negedge clk); rstn = 1;
        advance();
        set_op(64'd3, 64'd5, 4'b0001, 5'd12);
        set_done(0); sample(); advance(); sample(); advance();
        sample();
        chk("rst_mul_rv", 64'(rv), 64'd1); chk("rst_mul_res", res, 64'd15);
        chk("rst_mul_rd", 64'(o_rd), 64'd12);
        advance();
        valid = 0;

        // Back-to-back MUL then DIV; EX advances only when not stalled.
        div_lat = 4; idx = 0; pulses = 0;
        for (int i = 0; i < 30; i++) begin
            if (idx == 0)      set_op(64'd11, 64'd13, 4'b0000, 5'd1);
            else if (idx == 1) set_op(64'd200, 64'd9, 4'b0100, 5'd2);
            else               valid = 0;
            set_done(0);
            sample();
            if (rv) begin
                if (pulses < 2) begin p_rd[pulses] = o_rd; p_res[pulses] = res; end
                pulses++;
            end
            advance();
            if (ex_adv && idx < 2) idx++;
        end
        chk("b2b_pulses", 64'(pulses), 64'd2);
        chk("b2b_rd0", 64'(p_rd[0]), 64'd1);  chk("b2b_res0", p_res[0], 64'd143);
        chk("b2b_rd1", 64'(p_rd[1]), 64'd2);  chk("b2b_res1", p_res[1], 64'd22);

        // Randomized traffic with flushes, stale done pulses and bus noise.
        ex_adv = 1;
        for (int c = 0; c < 3000; c++) begin
            if (ex_adv) new_instr();
            if (m_busy) begin
                srca = {$urandom, $urandom};
                srcb = {$urandom, $urandom};
                ctl  = 4'($urandom);
                rd   = 5'($urandom);
            end else begin
                case ($urandom_range(0, 7))
                    0:       div_lat = TMO;
                    1:       div_lat = TMO + 5;
                    default: div_lat = $urandom_range(1, TMO - 1);
                endcase
            end
            flush = ($urandom_range(0, 15) == 0);
            junk  = {$urandom, $urandom};
            set_done($urandom_range(0, 9) == 0);
            sample();
            advance();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
